// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: host push side, status and transmitter handshake of the TX byte FIFO
//   master: environment (host writes, transmitter busy), slave: uart_tx_fifo
//   wr_en/wr_data/flush/clr_ovf  host controls
//   full/empty/count/ovf         FIFO status
//   tx_start/tx_data/tx_busy     launch handshake with the serial transmitter
interface uart_tx_fifo_if #(parameter int PTR_W = 4);
    logic             wr_en;
    logic [7:0]       wr_data;
    logic             flush;
    logic             clr_ovf;
    logic             full;
    logic             empty;
    logic [PTR_W:0]   count;
    logic             ovf;
    logic             tx_start;
    logic [7:0]       tx_data;
    logic             tx_busy;
    modport master (
        output wr_en, wr_data, flush, clr_ovf, tx_busy,
        input  full, empty, count, ovf, tx_start, tx_data
    );
    modport slave (
        input  wr_en, wr_data, flush, clr_ovf, tx_busy,
        output full, empty, count, ovf, tx_start, tx_data
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO that launches queued characters into a start/busy serial transmitter
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    uart_tx_fifo_if.slave: host push/flush/clr_ovf, status, tx_start/tx_data/tx_busy
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input logic           clk,
    input logic           rst_n,
    uart_tx_fifo_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_IDLE} state_t;
    state_t           state, state_d;
    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic [1:0]       guard, guard_d;
    logic [7:0]       tx_data;
    logic             ovf, tx_start, push, pop, drop;
    assign bus.full     = count == (PTR_W+1)'(DEPTH);
    assign bus.empty    = count == '0;
    assign bus.count    = count;
    assign bus.ovf      = ovf;
    assign bus.tx_start = tx_start;
    assign bus.tx_data  = tx_data;
    // full is the pre-pop value, so a push into a full FIFO drops even if a pop happens now
    assign drop = bus.wr_en && bus.full;
    assign push = bus.wr_en && !bus.full && !bus.flush;
    always_comb begin
        state_d = state;
        guard_d = guard;
        pop     = 1'b0;
        case (state)
            IDLE: if (!bus.empty && !bus.tx_busy && !bus.flush) begin
                pop     = 1'b1;
                state_d = LAUNCH;
            end
            LAUNCH: begin
                guard_d = '0;
                state_d = WAIT_BUSY;
            end
            // give up after 3 cycles without busy so a silent transmitter cannot hang us
            WAIT_BUSY: if (bus.tx_busy) state_d = WAIT_IDLE;
                       else if (guard == 2'd2) state_d = IDLE;
                       else guard_d = guard + 2'd1;
            WAIT_IDLE: if (!bus.tx_busy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            guard    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            state    <= state_d;
            guard    <= guard_d;
            tx_start <= pop;
            ovf      <= drop || (ovf && !bus.clr_ovf);
            if (pop) tx_data <= mem[rd_ptr];
            if (bus.flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
                count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.wr_data;
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed tests with a launch scoreboard and a simple transmitter busy model
module tb_uart_tx_fifo;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    uart_tx_fifo_if #(.PTR_W(4)) bus ();
    uart_tx_fifo #(.DEPTH(16), .PTR_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    int n_checks = 0;
    int n_fail = 0;
    int launches = 0;
    logic [7:0] exp_q [$];
    logic force_hi = 1'b0;
    logic tie_lo = 1'b0;
    logic prev_start = 1'b0;
    int busy_len = 3;
    int busy_cnt = 0;
    assign bus.tx_busy = force_hi || (busy_cnt != 0);
    always @(posedge clk)
        busy_cnt <= (bus.tx_start && !tie_lo) ? busy_len : (busy_cnt > 0 ? busy_cnt - 1 : 0);
    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask
    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask
    task automatic push(input logic [7:0] d, input bit acc);
        bus.wr_en = 1'b1;
        bus.wr_data = d;
        if (acc) exp_q.push_back(d);
        tick();
        bus.wr_en = 1'b0;
    endtask
    task automatic drain(input int bound);
        for (int i = 0; i < bound && exp_q.size() != 0; i++) tick();
        chk("drain_left", exp_q.size(), 0);
    endtask
    always @(negedge clk) begin
        if (rst_n && bus.tx_start) begin
            launches++;
            chk("tx_start_width", int'(prev_start), 0);
            if (exp_q.size() == 0) chk("unexpected_launch", int'(bus.tx_data), -1);
            else chk("tx_data_order", int'(bus.tx_data), int'(exp_q.pop_front()));
        end
        prev_start = rst_n && bus.tx_start;
    end
    initial begin
        #100000;
        $display("FAIL timeout: actual running required finished");
        $fatal(1, "timeout");
    end
    initial begin
        int l0;
        logic [7:0] held;
        bus.wr_en = 1'b0;
        bus.wr_data = 8'h00;
        bus.flush = 1'b0;
        bus.clr_ovf = 1'b0;
        tick(3);
        rst_n = 1'b1;
        chk("rst_count", int'(bus.count), 0);
        chk("rst_empty", int'(bus.empty), 1);
        chk("rst_full", int'(bus.full), 0);
        chk("rst_ovf", int'(bus.ovf), 0);
        chk("rst_tx_start", int'(bus.tx_start), 0);
        chk("rst_tx_data", int'(bus.tx_data), 0);
        // single byte: launch two edges after the push
        push(8'h41, 1'b1);
        chk("t1_count_after_push", int'(bus.count), 1);
        chk("t1_no_start_yet", int'(bus.tx_start), 0);
        tick();
        chk("t1_start", int'(bus.tx_start), 1);
        chk("t1_tx_data", int'(bus.tx_data), 'h41);
        chk("t1_count_after_pop", int'(bus.count), 0);
        chk("t1_empty", int'(bus.empty), 1);
        tick();
        chk("t1_start_drop", int'(bus.tx_start), 0);
        tick(10);
        // fill while transmitter busy
        force_hi = 1'b1;
        for (int i = 0; i < 16; i++) push(8'(i), 1'b1);
        chk("t2_full", int'(bus.full), 1);
        chk("t2_count", int'(bus.count), 16);
        // overflow and sticky flag
        push(8'hAA, 1'b0);
        chk("t3_ovf", int'(bus.ovf), 1);
        chk("t3_count", int'(bus.count), 16);
        bus.clr_ovf = 1'b1;
        tick();
        bus.clr_ovf = 1'b0;
        chk("t3_ovf_clr", int'(bus.ovf), 0);
        bus.clr_ovf = 1'b1;
        push(8'hAB, 1'b0);
        bus.clr_ovf = 1'b0;
        chk("t3_ovf_set_wins", int'(bus.ovf), 1);
        bus.clr_ovf = 1'b1;
        tick();
        bus.clr_ovf = 1'b0;
        l0 = launches;
        force_hi = 1'b0;
        drain(300);
        chk("t2_launches", launches - l0, 16);
        chk("t2_empty", int'(bus.empty), 1);
        tick(10);
        // advance pointers to 15, then push during a pop across the wrap
        force_hi = 1'b1;
        for (int i = 0; i < 14; i++) push(8'h20 + 8'(i), 1'b1);
        force_hi = 1'b0;
        drain(300);
        tick(10);
        force_hi = 1'b1;
        for (int i = 0; i < 5; i++) push(8'h50 + 8'(i), 1'b1);
        chk("t4_count5", int'(bus.count), 5);
        force_hi = 1'b0;
        push(8'h55, 1'b1);
        chk("t4_count_same", int'(bus.count), 5);
        chk("t4_start", int'(bus.tx_start), 1);
        drain(300);
        tick(10);
        // flush while a character is in flight
        force_hi = 1'b1;
        for (int i = 0; i < 8; i++) push(8'h60 + 8'(i), 1'b1);
        chk("t5_count8", int'(bus.count), 8);
        busy_len = 20;
        force_hi = 1'b0;
        tick(3);
        chk("t5_count7", int'(bus.count), 7);
        held = bus.tx_data;
        bus.flush = 1'b1;
        exp_q.delete();
        l0 = launches;
        tick();
        bus.flush = 1'b0;
        chk("t5_flush_count", int'(bus.count), 0);
        chk("t5_flush_empty", int'(bus.empty), 1);
        chk("t5_tx_data_held", int'(bus.tx_data), int'(held));
        tick(40);
        chk("t5_no_launch", launches - l0, 0);
        chk("t5_tx_data_final", int'(bus.tx_data), 'h60);
        busy_len = 3;
        // silent transmitter: guard timeout then next launch
        tie_lo = 1'b1;
        bus.wr_en = 1'b1;
        bus.wr_data = 8'h71;
        exp_q.push_back(8'h71);
        tick();
        bus.wr_data = 8'h72;
        exp_q.push_back(8'h72);
        tick();
        bus.wr_en = 1'b0;
        chk("t6_first_start", int'(bus.tx_start), 1);
        tick(4);
        chk("t6_gap", int'(bus.tx_start), 0);
        tick();
        chk("t6_second_start", int'(bus.tx_start), 1);
        chk("t6_second_data", int'(bus.tx_data), 'h72);
        tick(8);
        tie_lo = 1'b0;
        // async reset during WAIT_IDLE
        busy_len = 20;
        force_hi = 1'b1;
        push(8'h80, 1'b1);
        push(8'h81, 1'b1);
        push(8'h82, 1'b1);
        force_hi = 1'b0;
        tick(4);
        chk("t7_count", int'(bus.count), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_rst_count", int'(bus.count), 0);
        chk("t7_rst_empty", int'(bus.empty), 1);
        chk("t7_rst_tx_data", int'(bus.tx_data), 0);
        chk("t7_rst_tx_start", int'(bus.tx_start), 0);
        chk("t7_rst_ovf", int'(bus.ovf), 0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        l0 = launches;
        tick(30);
        chk("t7_no_launch", launches - l0, 0);
        chk("t7_empty_after", int'(bus.empty), 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
